// File: rtl/apb_spi_master.sv
// APB requester: takes one bridge request at a time and runs SETUP/ACCESS beats toward the SPI register file.
// 64-bit writes are split into two 32-bit beats; ACCESS is aborted after TIMEOUT cycles without PREADY.
module apb_spi_master #(
   parameter int ADDR_W  = 16,
   parameter int PDATA_W = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   input  logic                 s_w_r,
   input  logic [ADDR_W-1:0]    apb_addr,
   input  logic [2*PDATA_W-1:0] apb_data,
   output logic                 recev,
   output logic                 done,
   output logic                 resp_err,
   output logic [7:0]           spi_read_data,
   output logic [ADDR_W-1:0]    PADDR,
   output logic                 PSEL,
   output logic                 PENABLE,
   output logic                 PWRITE,
   output logic [PDATA_W-1:0]   PWDATA,
   input  logic [PDATA_W-1:0]   PRDATA,
   input  logic                 PREADY,
   input  logic                 PSLVERR
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   localparam logic [7:0] TO = 8'(TIMEOUT);

   state_t               state_q, state_d;
   logic                 recev_q, recev_d;
   logic                 done_q, done_d;
   logic                 resp_err_q, resp_err_d;
   logic [7:0]           rdata_q, rdata_d;
   logic [ADDR_W-1:0]    paddr_q, paddr_d;
   logic                 psel_q, psel_d;
   logic                 penable_q, penable_d;
   logic                 pwrite_q, pwrite_d;
   logic [PDATA_W-1:0]   pwdata_q, pwdata_d;
   logic                 beat_q, beat_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [2*PDATA_W-1:0] word_q, word_d;
   logic                 rd_q, rd_d;
   logic                 fin;
   logic                 err;

   // Only the low byte of PRDATA is returned to the bridge.
   logic unused_prdata;
   assign unused_prdata = ^PRDATA[PDATA_W-1:8];

   always_comb begin
      state_d    = state_q;
      recev_d    = recev_q;
      done_d     = 1'b0;
      resp_err_d = 1'b0;
      rdata_d    = rdata_q;
      paddr_d    = paddr_q;
      psel_d     = psel_q;
      penable_d  = penable_q;
      pwrite_d   = pwrite_q;
      pwdata_d   = pwdata_q;
      beat_d     = beat_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      word_d     = word_q;
      rd_d       = rd_q;
      fin        = 1'b0;
      err        = 1'b0;

      case (state_q)
         // DONE already shows recev=0, so a waiting request is taken straight from there.
         IDLE, DONE: begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            if (req_valid && !recev_q) begin
               addr_d   = apb_addr;
               word_d   = apb_data;
               rd_d     = s_w_r;
               beat_d   = 1'b0;
               recev_d  = 1'b1;
               state_d  = SETUP;
               psel_d   = 1'b1;
               pwrite_d = ~s_w_r;
               paddr_d  = apb_addr;
               pwdata_d = apb_data[PDATA_W-1:0];
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
            cnt_d     = 8'd0;
         end
         ACCESS: begin
            if (PREADY) begin
               if (PSLVERR) begin
                  fin = 1'b1;
                  err = 1'b1;
               end else if (rd_q) begin
                  rdata_d = PRDATA[7:0];
                  fin     = 1'b1;
               end else if (!beat_q) begin
                  beat_d    = 1'b1;
                  state_d   = SETUP;
                  penable_d = 1'b0;
                  paddr_d   = addr_q + ADDR_W'(4);
                  pwdata_d  = word_q[2*PDATA_W-1:PDATA_W];
               end else begin
                  fin = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == TO) begin
                  fin = 1'b1;
                  err = 1'b1;
               end
            end
            if (fin) begin
               state_d    = DONE;
               psel_d     = 1'b0;
               penable_d  = 1'b0;
               done_d     = 1'b1;
               resp_err_d = err;
               recev_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         recev_q    <= 1'b0;
         done_q     <= 1'b0;
         resp_err_q <= 1'b0;
         rdata_q    <= 8'd0;
         paddr_q    <= '0;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         pwdata_q   <= '0;
         beat_q     <= 1'b0;
         cnt_q      <= 8'd0;
         addr_q     <= '0;
         word_q     <= '0;
         rd_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         recev_q    <= recev_d;
         done_q     <= done_d;
         resp_err_q <= resp_err_d;
         rdata_q    <= rdata_d;
         paddr_q    <= paddr_d;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         pwrite_q   <= pwrite_d;
         pwdata_q   <= pwdata_d;
         beat_q     <= beat_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
         rd_q       <= rd_d;
      end
   end

   assign recev         = recev_q;
   assign done          = done_q;
   assign resp_err      = resp_err_q;
   assign spi_read_data = rdata_q;
   assign PADDR         = paddr_q;
   assign PSEL          = psel_q;
   assign PENABLE       = penable_q;
   assign PWRITE        = pwrite_q;
   assign PWDATA        = pwdata_q;

endmodule

// File: doc/apb_spi_master.md
Name: apb_spi_master

Overview:
- APB requester stage directly downstream of the AXI-to-APB bridge FIFO drain logic.
- Takes one queued request at a time (16-bit address, 64-bit write word, or byte read) and runs APB SETUP/ACCESS phases toward the SPI peripheral register file.
- Splits each 64-bit write into two 32-bit APB beats.
- Reports busy (recev), completion and error status back to the bridge, and returns read data on spi_read_data.

Parameters:
- ADDR_W, 16: request and PADDR width.
- PDATA_W, 32: PWDATA/PRDATA width; the request word is 2*PDATA_W.
- TIMEOUT, 15: maximum ACCESS cycles to wait for PREADY before aborting. Valid range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  bridge presents a request.
- s_w_r  input  1  request type: 0 = write, 1 = read.
- apb_addr  input  ADDR_W  request byte address.
- apb_data  input  2*PDATA_W  write word; ignored for reads.
- recev  output  1  busy; a request is accepted only while recev=0.
- done  output  1  one-cycle pulse when a request completes or aborts.
- resp_err  output  1  valid with done: 1 = PSLVERR or timeout.
- spi_read_data  output  8  PRDATA[7:0] of the last successful read; holds until the next successful read.
- PADDR  output  ADDR_W  APB address.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PWDATA  output  PDATA_W  APB write data.
- PRDATA  input  PDATA_W  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB error.

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE. recev, done, resp_err, PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA, spi_read_data = 0; beat flag and timeout counter = 0. A reset during any phase deasserts PSEL/PENABLE immediately (no clock needed) and discards the request.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If req_valid=1 and recev=0: capture apb_addr, s_w_r and apb_data into internal registers; set recev=1, beat=0, go to SETUP.
  - Otherwise stay in IDLE.
- SETUP (exactly one cycle):
  - PSEL=1, PENABLE=0, PWRITE=~s_w_r.
  - PADDR = addr + 4*beat, modulo 2^ADDR_W (wraps from 0xFFFC to 0x0000).
  - PWDATA = word[31:0] when beat=0, word[63:32] when beat=1.
  - Next state ACCESS; timeout counter cleared.
- ACCESS:
  - PSEL=1, PENABLE=1; PADDR/PWDATA/PWRITE held stable.
  - PREADY=0: counter increments. When the counter reaches TIMEOUT, set err and go to DONE.
  - PREADY=1 and PSLVERR=1: set err, go to DONE. No second beat is issued.
  - PREADY=1 and PSLVERR=0:
    - Read: spi_read_data <= PRDATA[7:0]; go to DONE.
    - Write, beat=0: beat <= 1, go to SETUP.
    - Write, beat=1: go to DONE.
  - PSLVERR is sampled only when PREADY=1.
- DONE (one cycle):
  - PSEL=0, PENABLE=0.
  - done=1, resp_err=err, recev=0; next state IDLE; err cleared on exit.
- Latency, request accepted at edge N, zero wait states:
  - Read: SETUP N+1, ACCESS N+2, done high in cycle N+3, recev low from N+3. The next request can be accepted at edge N+3.
  - Write: SETUP N+1, ACCESS N+2, SETUP N+3, ACCESS N+4, done in cycle N+5.
  - Each wait state adds one cycle.
- req_valid while recev=1 is ignored and nothing is queued. The bridge must hold its request until it observes recev=0 and the request is accepted.
- PSEL and PENABLE never both high outside ACCESS. PENABLE is never high without PSEL.

Test Plan:
- Write addr=0x0010, data=0x1122334455667788, PREADY=1 → beat 1: PADDR=0x0010, PWDATA=0x55667788. Beat 2: PADDR=0x0014, PWDATA=0x11223344. done at N+5, resp_err=0.
- Read addr=0x0004, PRDATA=0x000000A5, PREADY delayed 3 cycles → spi_read_data=0xA5. PENABLE high for 4 cycles. done at N+6, resp_err=0.
- Write with PSLVERR=1 on beat 1 → only one SETUP/ACCESS pair, done with resp_err=1, PADDR 0x0014 never driven.
- PREADY stuck low, TIMEOUT=15 → ACCESS lasts 15 cycles, then done with resp_err=1. recev=0 on the next cycle and a new request is accepted.
- Write addr=0xFFFC → beat 2 PADDR=0x0000.
- Assert reset=0 mid-ACCESS without a clock edge → PSEL=PENABLE=recev=0 immediately. After release, a fresh read completes normally.
